// File: rtl/bp_table_update_scheduler_pkg.sv
// Shared types and default sizing for the PHT update scheduler.
package bp_table_update_scheduler_pkg;

  localparam int unsigned PHT_INDEX_LENGTH_DEFAULT   = 8;
  localparam int unsigned UPDATE_QUEUE_DEPTH_DEFAULT = 4;
  localparam logic [1:0]  PHT_INIT_VALUE_DEFAULT     = 2'b01;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_sched_state_type;

endpackage

// File: rtl/bp_table_update_scheduler_update_queue.sv
// Update FIFO for pending PHT counter writes, with a parallel index compare that
// returns the youngest queued counter for a lookup address.
module bp_table_update_scheduler_update_queue
  import bp_table_update_scheduler_pkg::*;
#(
  parameter int unsigned INDEX_W = PHT_INDEX_LENGTH_DEFAULT,
  parameter int unsigned DEPTH   = UPDATE_QUEUE_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic [INDEX_W-1:0]         i_push_index,
  input  logic [1:0]                 i_push_counter,
  input  logic                       i_pop,
  output logic [INDEX_W-1:0]         o_head_index,
  output logic [1:0]                 o_head_counter,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty,
  input  logic [INDEX_W-1:0]         i_lookup_index,
  output logic                       o_fwd_hit,
  output logic [1:0]                 o_fwd_counter
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic [1:0]         counter;
  } pht_update_entry_type;

  pht_update_entry_type r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_clr) r_mem[r_wr_ptr] <= '{index: i_push_index, counter: i_push_counter};
  end

  assign o_head_index   = r_mem[r_rd_ptr].index;
  assign o_head_counter = r_mem[r_rd_ptr].counter;
  assign o_count        = r_count;
  assign o_full         = (r_count == CNT_W'(DEPTH));
  assign o_empty        = (r_count == '0);

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    logic [PTR_W-1:0] w_slot;
    o_fwd_hit     = 1'b0;
    o_fwd_counter = '0;
    w_slot        = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      w_slot = r_rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < r_count) && (r_mem[w_slot].index == i_lookup_index)) begin
        o_fwd_hit     = 1'b1;
        o_fwd_counter = r_mem[w_slot].counter;
      end
    end
  end

endmodule

// File: rtl/bp_table_update_scheduler.sv
// Owns the single-port PHT: init sweep after reset/flush, then arbitrates IF lookups
// against queued EX counter writes and forwards pending values to lookups.
module bp_table_update_scheduler
  import bp_table_update_scheduler_pkg::*;
#(
  parameter int unsigned PHT_INDEX_LENGTH   = PHT_INDEX_LENGTH_DEFAULT,
  parameter int unsigned UPDATE_QUEUE_DEPTH = UPDATE_QUEUE_DEPTH_DEFAULT,
  parameter logic [1:0]  PHT_INIT_VALUE     = PHT_INIT_VALUE_DEFAULT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush_req,
  input  logic                                upd_valid,
  input  logic [PHT_INDEX_LENGTH-1:0]         upd_index,
  input  logic [1:0]                          upd_counter,
  output logic                                upd_ready,
  input  logic                                lookup_req,
  input  logic [PHT_INDEX_LENGTH-1:0]         lookup_index,
  output logic                                lookup_grant,
  output logic                                fwd_hit,
  output logic [1:0]                          fwd_counter,
  output logic                                pht_en,
  output logic                                pht_we,
  output logic [PHT_INDEX_LENGTH-1:0]         pht_addr,
  output logic [1:0]                          pht_wdata,
  output logic                                init_busy,
  output logic [$clog2(UPDATE_QUEUE_DEPTH):0] queue_count
);

  bp_sched_state_type            r_state;
  logic [PHT_INDEX_LENGTH-1:0]   r_init_ptr;

  logic                          w_run;
  logic                          w_full;
  logic                          w_empty;
  logic                          w_push;
  logic                          w_pop;
  logic [PHT_INDEX_LENGTH-1:0]   w_head_index;
  logic [1:0]                    w_head_counter;
  logic                          w_fwd_hit;
  logic [1:0]                    w_fwd_counter;

  assign w_run     = (r_state == RUN);
  assign init_busy = !w_run;
  assign upd_ready = w_run && !w_full;
  // A flush in the same cycle discards the incoming update.
  assign w_push    = upd_valid && upd_ready && !flush_req;
  assign w_pop     = w_run && (w_full || (!lookup_req && !w_empty));

  assign lookup_grant = w_run && !w_full && lookup_req;
  assign fwd_hit      = w_run && w_fwd_hit;
  assign fwd_counter  = w_fwd_counter;

  always_comb begin
    pht_en    = 1'b0;
    pht_we    = 1'b0;
    pht_addr  = '0;
    pht_wdata = w_head_counter;
    if (!w_run) begin
      pht_en    = 1'b1;
      pht_we    = 1'b1;
      pht_addr  = r_init_ptr;
      pht_wdata = PHT_INIT_VALUE;
    end else if (w_pop) begin
      pht_en    = 1'b1;
      pht_we    = 1'b1;
      pht_addr  = w_head_index;
    end else if (lookup_grant) begin
      pht_en    = 1'b1;
      pht_addr  = lookup_index;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= INIT;
      r_init_ptr <= '0;
    end else begin
      unique case (r_state)
        INIT: begin
          if (flush_req) begin
            r_init_ptr <= '0;
          end else begin
            r_init_ptr <= r_init_ptr + PHT_INDEX_LENGTH'(1);
            if (r_init_ptr == '1) r_state <= RUN;
          end
        end
        RUN: begin
          if (flush_req) begin
            r_state    <= INIT;
            r_init_ptr <= '0;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  bp_table_update_scheduler_update_queue #(
    .INDEX_W (PHT_INDEX_LENGTH),
    .DEPTH   (UPDATE_QUEUE_DEPTH)
  ) u_update_queue (
    .clk            (clk),
    .rst            (rst),
    .i_clr          (flush_req),
    .i_push         (w_push),
    .i_push_index   (upd_index),
    .i_push_counter (upd_counter),
    .i_pop          (w_pop),
    .o_head_index   (w_head_index),
    .o_head_counter (w_head_counter),
    .o_count        (queue_count),
    .o_full         (w_full),
    .o_empty        (w_empty),
    .i_lookup_index (lookup_index),
    .o_fwd_hit      (w_fwd_hit),
    .o_fwd_counter  (w_fwd_counter)
  );

endmodule

// File: tb/tb_bp_table_update_scheduler.sv
// Bench for bp_table_update_scheduler: directed scenarios plus random traffic,
// compared against a queue-based behavioural model every cycle.
module tb_bp_table_update_scheduler;

  localparam int IDXW  = 4;
  localparam int DEPTH = 4;
  localparam int NENT  = 1 << IDXW;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush_req;
  logic            upd_valid;
  logic [IDXW-1:0] upd_index;
  logic [1:0]      upd_counter;
  logic            upd_ready;
  logic            lookup_req;
  logic [IDXW-1:0] lookup_index;
  logic            lookup_grant;
  logic            fwd_hit;
  logic [1:0]      fwd_counter;
  logic            pht_en;
  logic            pht_we;
  logic [IDXW-1:0] pht_addr;
  logic [1:0]      pht_wdata;
  logic            init_busy;
  logic [2:0]      queue_count;

  always #5 clk = ~clk;

  bp_table_update_scheduler #(
    .PHT_INDEX_LENGTH   (IDXW),
    .UPDATE_QUEUE_DEPTH (DEPTH),
    .PHT_INIT_VALUE     (2'b01)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_req    (flush_req),
    .upd_valid    (upd_valid),
    .upd_index    (upd_index),
    .upd_counter  (upd_counter),
    .upd_ready    (upd_ready),
    .lookup_req   (lookup_req),
    .lookup_index (lookup_index),
    .lookup_grant (lookup_grant),
    .fwd_hit      (fwd_hit),
    .fwd_counter  (fwd_counter),
    .pht_en       (pht_en),
    .pht_we       (pht_we),
    .pht_addr     (pht_addr),
    .pht_wdata    (pht_wdata),
    .init_busy    (init_busy),
    .queue_count  (queue_count)
  );

  typedef struct packed {
    logic [IDXW-1:0] idx;
    logic [1:0]      cnt;
  } ent_t;

  // Model: sweeping flag + sweep address, and the pending updates oldest-first.
  bit   m_init;
  int   m_ptr;
  ent_t m_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 1'b1;
    m_ptr  = 0;
    m_q.delete();
  endtask

  // Called just after a negedge with inputs set: check outputs, cross the posedge,
  // advance the model, return at the next negedge.
  task automatic cycle();
    bit   e_write, e_ready, e_grant, e_hit;
    logic [1:0] e_fc;
    ent_t head;
    #1;
    e_write = 1'b0;
    e_ready = 1'b0;
    if (m_init) begin
      chk("init_busy", init_busy, 1);
      chk("init_en", pht_en, 1);
      chk("init_we", pht_we, 1);
      chk("init_addr", pht_addr, m_ptr);
      chk("init_wdata", pht_wdata, 2'b01);
      chk("init_ready", upd_ready, 0);
      chk("init_grant", lookup_grant, 0);
      chk("init_fwd_hit", fwd_hit, 0);
      chk("init_count", queue_count, 0);
    end else begin
      e_ready = (m_q.size() < DEPTH);
      e_write = !e_ready || (!lookup_req && m_q.size() > 0);
      e_grant = e_ready && lookup_req;
      chk("run_busy", init_busy, 0);
      chk("run_ready", upd_ready, e_ready);
      chk("run_grant", lookup_grant, e_grant);
      chk("run_count", queue_count, m_q.size());
      chk("run_en", pht_en, e_write || e_grant);
      if (e_write) begin
        head = m_q[0];
        chk("wr_we", pht_we, 1);
        chk("wr_addr", pht_addr, head.idx);
        chk("wr_wdata", pht_wdata, head.cnt);
      end else if (e_grant) begin
        chk("rd_we", pht_we, 0);
        chk("rd_addr", pht_addr, lookup_index);
      end
      e_hit = 1'b0;
      e_fc  = 2'b00;
      foreach (m_q[i]) begin
        if (m_q[i].idx == lookup_index) begin
          e_hit = 1'b1;
          e_fc  = m_q[i].cnt;
        end
      end
      chk("fwd_hit", fwd_hit, e_hit);
      if (e_hit) chk("fwd_counter", fwd_counter, e_fc);
    end
    @(posedge clk);
    if (m_init) begin
      if (flush_req) m_ptr = 0;
      else if (m_ptr == NENT - 1) begin
        m_init = 1'b0;
        m_ptr  = 0;
      end else m_ptr++;
    end else if (flush_req) begin
      model_reset();
    end else begin
      if (e_write) void'(m_q.pop_front());
      if (upd_valid && e_ready) m_q.push_back('{idx: upd_index, cnt: upd_counter});
    end
    @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    flush_req    = 1'b0;
    upd_valid    = 1'b0;
    upd_index    = '0;
    upd_counter  = '0;
    lookup_req   = 1'b0;
    lookup_index = '0;
    model_reset();
    #3;
    chk("rst_busy", init_busy, 1);
    chk("rst_count", queue_count, 0);
    chk("rst_addr", pht_addr, 0);
    chk("rst_ready", upd_ready, 0);
    @(negedge clk);
    rst = 1'b0;

    // Full init sweep, then the first RUN cycle.
    repeat (NENT) cycle();
    cycle();

    // Single update drains on the next idle cycle.
    upd_valid = 1'b1; upd_index = 4'd5; upd_counter = 2'd3;
    cycle();
    upd_valid = 1'b0;
    cycle();
    cycle();

    // Lookups hold the port while the queue fills; full forces a write.
    lookup_req = 1'b1; lookup_index = 4'd0;
    for (int i = 0; i < DEPTH; i++) begin
      upd_valid = 1'b1; upd_index = IDXW'(i + 1); upd_counter = 2'(i);
      cycle();
    end
    upd_valid = 1'b0;
    cycle();
    cycle();
    lookup_req = 1'b0;
    repeat (DEPTH) cycle();

    // Youngest matching entry is forwarded.
    lookup_req = 1'b1; lookup_index = 4'd9;
    upd_valid = 1'b1; upd_index = 4'd9; upd_counter = 2'd2;
    cycle();
    upd_counter = 2'd3;
    cycle();
    upd_index = 4'd4; upd_counter = 2'd1;
    cycle();
    upd_valid = 1'b0;
    cycle();

    // Flush with 3 entries queued (and a colliding update), then a flush mid-sweep.
    flush_req = 1'b1; upd_valid = 1'b1; upd_index = 4'd7;
    cycle();
    flush_req = 1'b0; upd_valid = 1'b0; lookup_req = 1'b0;
    repeat (7) cycle();
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    repeat (NENT + 2) cycle();

    // Random traffic with small index ranges so forwarding hits are frequent.
    repeat (400) begin
      upd_valid    = 1'($urandom_range(0, 1));
      upd_index    = IDXW'($urandom_range(0, 7));
      upd_counter  = 2'($urandom_range(0, 3));
      lookup_req   = ($urandom_range(0, 2) != 0);
      lookup_index = IDXW'($urandom_range(0, 7));
      flush_req    = ($urandom_range(0, 99) == 0);
      cycle();
    end

    // Settle in RUN, queue two entries, then assert reset mid-cycle.
    flush_req = 1'b0; upd_valid = 1'b0; lookup_req = 1'b0;
    repeat (NENT + DEPTH + 2) cycle();
    lookup_req = 1'b1; lookup_index = 4'd15;
    upd_valid = 1'b1; upd_index = 4'd2; upd_counter = 2'd2;
    cycle();
    upd_index = 4'd3;
    cycle();
    upd_valid = 1'b0;
    cycle();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", queue_count, 0);
    chk("arst_busy", init_busy, 1);
    chk("arst_addr", pht_addr, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0; lookup_req = 1'b0;
    repeat (NENT + 1) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_table_update_scheduler.md
Name: bp_table_update_scheduler

Overview:
- Owns the single-port pattern history table (PHT) shared by the IF-stage predictor lookup and the EX-stage branch resolution writeback.
- Queues EX counter updates in a small FIFO and arbitrates the PHT port between lookups and queued writes.
- Forwards pending update values to lookups so reads never see stale counters.
- Sequences a full-table initialization sweep after reset and on flush.

Parameters:
- PHT_INDEX_LENGTH, 8, PHT address width; the table has 2**PHT_INDEX_LENGTH 2-bit entries.
- UPDATE_QUEUE_DEPTH, 4, number of update FIFO entries; must be a power of two, ≥2.
- PHT_INIT_VALUE, 2'b01, counter value written by the init sweep (weakly not-taken).

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high
- flush_req  in  1  re-initialize the table (pulse)
- upd_valid  in  1  EX update request; driven from br_update_ex.update
- upd_index  in  PHT_INDEX_LENGTH  PHT index of the resolved branch
- upd_counter  in  2  new counter value (LBP/GBP_predict_update)
- upd_ready  out  1  queue can accept an update this cycle
- lookup_req  in  1  IF lookup request
- lookup_index  in  PHT_INDEX_LENGTH  lookup address
- lookup_grant  out  1  lookup owns the PHT port this cycle
- fwd_hit  out  1  lookup_index matches a queued entry
- fwd_counter  out  2  counter from the youngest matching queued entry
- pht_en  out  1  PHT port enable
- pht_we  out  1  PHT write enable
- pht_addr  out  PHT_INDEX_LENGTH  PHT address
- pht_wdata  out  2  PHT write data
- init_busy  out  1  init sweep in progress
- queue_count  out  $clog2(UPDATE_QUEUE_DEPTH)+1  occupied entries

Behaviour:
- FSM states: INIT and RUN. Async rst forces INIT, init_ptr=0, queue empty, queue_count=0.
- Port outputs are combinational from state, queue head and the lookup inputs. The queue, init_ptr and state are registered.
- INIT:
  - Drives pht_en=1, pht_we=1, pht_addr=init_ptr, pht_wdata=PHT_INIT_VALUE.
  - init_ptr increments each cycle. After writing the last index, the FSM goes to RUN; the sweep takes exactly 2**PHT_INDEX_LENGTH cycles.
  - While in INIT: init_busy=1, upd_ready=0, lookup_grant=0, fwd_hit=0. upd_valid is dropped and lookup_req is ignored.
- RUN:
  - init_busy=0; upd_ready = (queue_count != UPDATE_QUEUE_DEPTH).
  - Enqueue when upd_valid && upd_ready. Entry = {upd_index, upd_counter}, appended at the tail.
  - Arbitration order:
    1. Queue full: head is written (pht_we=1); lookup_grant=0.
    2. Else lookup_req=1: lookup_grant=1, pht_en=1, pht_we=0, pht_addr=lookup_index.
    3. Else queue non-empty: head is written and dequeued.
    4. Else pht_en=0.
  - Write cycle: pht_addr=head index, pht_wdata=head counter; the head is dequeued in that cycle.
  - Enqueue and dequeue in the same cycle: count unchanged, both pointers advance.
  - Full queue: the write drains one entry, but upd_ready is already 0 that cycle, so no enqueue. upd_ready returns to 1 the next cycle.
- Forwarding (RUN only):
  - fwd_hit=1 if any valid entry's index equals lookup_index; fwd_counter comes from the youngest such entry.
  - The IF stage uses fwd_counter over PHT read data when fwd_hit=1.
  - The entry being dequeued in the current cycle still counts for forwarding.
- flush_req:
  - In RUN: next cycle state=INIT, init_ptr=0, queue cleared (pending updates discarded).
  - In INIT: init_ptr restarts at 0.
  - flush_req has priority over enqueue in the same cycle; the update is dropped.
- Pointers wrap modulo UPDATE_QUEUE_DEPTH. queue_count never exceeds UPDATE_QUEUE_DEPTH.
- Asserting rst mid-sweep or mid-drain returns the block to the reset state immediately; no partial-write guarantees.

Decomposition:
- RVS192_user_parameters: PHT_INDEX_LENGTH, UPDATE_QUEUE_DEPTH, PHT_INIT_VALUE.
- RVS192_package: enum bp_sched_state_type {INIT, RUN}; struct pht_update_entry_type {index, counter}.
- One sub-module is natural: bp_update_queue, a FIFO with a parallel index-compare forwarding port. FSM and arbitration stay in the top module.

Test Plan:
- Reset release (PHT_INDEX_LENGTH=4): 16 write cycles with addr 0..15 and wdata 01, init_busy=1 throughout; cycle 17: state RUN, upd_ready=1.
- RUN, upd_valid with index 5, counter 3 and no lookups: queue_count=1. Next cycle: pht_we=1, addr=5, wdata=3; queue_count=0.
- Continuous lookup_req with 4 updates enqueued:
  - lookup_grant stays 1 and the queue fills to 4, upd_ready=0.
  - Next cycle: lookup_grant=0 and the head is written.
  - Following cycle: upd_ready=1.
- Enqueue index 9/counter 2, then index 9/counter 3, while lookup_index=9 is held: fwd_hit=1, fwd_counter=3.
- flush_req with 3 entries queued: next cycle init_busy=1, queue_count=0, sweep restarts at addr 0. A second flush_req mid-sweep at addr 7 restarts at 0.
- Assert rst during RUN with queue_count=2: queue_count=0 and init_busy=1 asynchronously, pht_addr=0.
